// File: rtl/lsu_axi_if.sv
// lsu_axi_if: execute-stage request/response plus AXI-lite master bus bundle
interface lsu_axi_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_sext, rsp_ready,
               arready, rdata, rvalid, awready, wready, bresp, bvalid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, araddr, arvalid, rready,
               awaddr, awvalid, wdata, wstrb, wvalid, bready
    );
    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_sext, rsp_ready,
               arready, rdata, rvalid, awready, wready, bresp, bvalid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, araddr, arvalid, rready,
               awaddr, awvalid, wdata, wstrb, wvalid, bready
    );
endinterface

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: single-outstanding load/store unit driving an AXI-lite master port
module lsu_axi_master #(
    parameter bit         ALIGN_CHECK = 1'b1,
    parameter logic [1:0] RESP_OK     = 2'b00
) (
    input logic        clk,
    input logic        rst,
    lsu_axi_if.master  bus
);
    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RSP} state_t;
    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic        aw_done, w_done, aw_done_nxt, w_done_nxt;
    logic [31:0] rsp_rdata_q, rsp_rdata_nxt;
    logic        rsp_err_q, rsp_err_nxt;
    logic [1:0]  off;
    logic [4:0]  sh;
    logic        req_err;
    logic [31:0] shifted, ld_data;
    assign off = addr_q[1:0];
    assign sh  = {off, 3'b000};
    assign req_err = (bus.req_size == 2'b11) ||
                     (ALIGN_CHECK && ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
                                      (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)));
    assign shifted = bus.rdata >> sh;
    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.arvalid   = (state == AR);
    assign bus.araddr    = {addr_q[31:2], 2'b00};
    assign bus.rready    = (state == R);
    assign bus.awvalid   = (state == AW_W) && !aw_done;
    assign bus.wvalid    = (state == AW_W) && !w_done;
    assign bus.awaddr    = {addr_q[31:2], 2'b00};
    assign bus.wdata     = wdata_q << sh;
    assign bus.bready    = (state == B);
    assign bus.rsp_valid = (state == RSP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    // byte lanes touched by the access, placed at the byte offset within the word
    always_comb
        bus.wstrb = size_q == 2'b00 ? 4'b0001 << off :
                    size_q == 2'b01 ? 4'b0011 << off : 4'b1111;
    // align read lane to bit 0, then mask to access size with zero or sign fill
    always_comb
        ld_data = size_q == 2'b00 ? {{24{sext_q & shifted[7]}}, shifted[7:0]} :
                  size_q == 2'b01 ? {{16{sext_q & shifted[15]}}, shifted[15:0]} : shifted;
    // next-state and response capture; address/write channels finish independently
    always_comb begin
        state_nxt     = state;
        aw_done_nxt   = aw_done;
        w_done_nxt    = w_done;
        rsp_rdata_nxt = rsp_rdata_q;
        rsp_err_nxt   = rsp_err_q;
        case (state)
            IDLE: if (bus.req_valid) begin
                state_nxt     = req_err ? RSP : bus.req_wen ? AW_W : AR;
                rsp_err_nxt   = req_err;
                rsp_rdata_nxt = '0;
                aw_done_nxt   = 1'b0;
                w_done_nxt    = 1'b0;
            end
            AR: if (bus.arready) state_nxt = R;
            R: if (bus.rvalid) begin
                state_nxt     = RSP;
                rsp_rdata_nxt = ld_data;
                rsp_err_nxt   = 1'b0;
            end
            AW_W: begin
                aw_done_nxt = aw_done | bus.awready;
                w_done_nxt  = w_done | bus.wready;
                if (aw_done_nxt && w_done_nxt) state_nxt = B;
            end
            B: if (bus.bvalid) begin
                state_nxt     = RSP;
                rsp_err_nxt   = bus.bresp != RESP_OK;
                rsp_rdata_nxt = '0;
            end
            RSP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // control state; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            aw_done     <= aw_done_nxt;
            w_done      <= w_done_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            rsp_err_q   <= rsp_err_nxt;
        end
    end
    // request fields held for the whole transaction so bus payloads stay stable
    always_ff @(posedge clk) begin
        if (bus.req_valid && bus.req_ready) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            sext_q  <= bus.req_sext;
        end
    end
endmodule
